// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IF/MEM memory-port arbiter: FSM states, MEMControl
// bit positions and requester identities.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACC_IF  = 2'd1,
      ST_ACC_MEM = 2'd2,
      ST_RESP    = 2'd3
   } state_e;

   localparam int MEMCTL_READ  = 1;
   localparam int MEMCTL_WRITE = 0;

   typedef enum logic {
      REQ_IF  = 1'b0,
      REQ_MEM = 1'b1
   } req_id_e;

   // On a conflict the requester that was not served last wins.
   function automatic req_id_e pick_requester(input logic    if_req,
                                              input logic    mem_req,
                                              input req_id_e last_served);
      req_id_e winner;
      if (if_req && mem_req) begin
         if (last_served == REQ_IF) winner = REQ_MEM;
         else                       winner = REQ_IF;
      end else if (mem_req) begin
         winner = REQ_MEM;
      end else begin
         winner = REQ_IF;
      end
      return winner;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_timer.sv
// Access-length down-counter: load starts a window of LATENCY cycles and
// last flags the final cycle of that window.
module mem_access_timer #(
   parameter int LATENCY = 2
) (
   input  logic clk,
   input  logic srst,
   input  logic load,
   output logic last
);

   localparam int CW = $clog2(LATENCY + 1);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = CW'(LATENCY);
      end else if (count_q != '0) begin
         count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (srst) count_q <= '0;
      else      count_q <= count_d;
   end

   assign last = (count_q == CW'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and the MEM
// stage; one fixed-length access at a time followed by a Done pulse.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int MEM_LATENCY = 2,
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              IFReq,
   input  logic [ADDR_W-1:0] IFAddress,
   output logic              IFDone,
   output logic [DATA_W-1:0] IFData,
   output logic              IFStall,
   input  logic [1:0]        MEMControl,
   input  logic [ADDR_W-1:0] MEMAddress,
   input  logic [DATA_W-1:0] MEMWriteData,
   output logic              MEMDone,
   output logic [DATA_W-1:0] MEMReadData,
   output logic              MEMStall,
   output logic [ADDR_W-1:0] MemAddr,
   output logic [DATA_W-1:0] MemWData,
   output logic              MemRead,
   output logic              MemWrite,
   input  logic [DATA_W-1:0] MemRData
);

   state_e            state_q, state_d;
   req_id_e           last_served_q, last_served_d;
   req_id_e           winner;
   logic              if_done_q, if_done_d;
   logic              mem_done_q, mem_done_d;
   logic [DATA_W-1:0] if_data_q, if_data_d;
   logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              mem_read_q, mem_read_d;
   logic              mem_write_q, mem_write_d;
   logic              mem_req;
   logic              timer_load;
   logic              timer_last;

   assign mem_req = |MEMControl;

   mem_access_timer #(
      .LATENCY (MEM_LATENCY)
   ) u_timer (
      .clk  (Clk),
      .srst (Reset),
      .load (timer_load),
      .last (timer_last)
   );

   always_comb begin
      state_d       = state_q;
      last_served_d = last_served_q;
      if_done_d     = 1'b0;
      mem_done_d    = 1'b0;
      if_data_d     = if_data_q;
      mem_rdata_d   = mem_rdata_q;
      mem_addr_d    = mem_addr_q;
      mem_wdata_d   = mem_wdata_q;
      mem_read_d    = mem_read_q;
      mem_write_d   = mem_write_q;
      timer_load    = 1'b0;
      winner        = pick_requester(IFReq, mem_req, last_served_q);

      case (state_q)
         ST_IDLE: begin
            if (IFReq || mem_req) begin
               timer_load = 1'b1;
               if (winner == REQ_MEM) begin
                  state_d     = ST_ACC_MEM;
                  mem_addr_d  = MEMAddress;
                  mem_wdata_d = MEMWriteData;
                  // 2'b11 is illegal and degrades to a plain read.
                  mem_read_d  = MEMControl[MEMCTL_READ];
                  mem_write_d = MEMControl[MEMCTL_WRITE] & ~MEMControl[MEMCTL_READ];
               end else begin
                  state_d     = ST_ACC_IF;
                  mem_addr_d  = IFAddress;
                  mem_wdata_d = '0;
                  mem_read_d  = 1'b1;
                  mem_write_d = 1'b0;
               end
            end
         end
         ST_ACC_IF, ST_ACC_MEM: begin
            if (timer_last) begin
               state_d     = ST_RESP;
               mem_read_d  = 1'b0;
               mem_write_d = 1'b0;
               if (state_q == ST_ACC_IF) begin
                  if_done_d = 1'b1;
                  if_data_d = MemRData;
               end else begin
                  mem_done_d = 1'b1;
                  if (mem_read_q) mem_rdata_d = MemRData;
               end
            end
         end
         ST_RESP: begin
            state_d       = ST_IDLE;
            last_served_d = if_done_q ? REQ_IF : REQ_MEM;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q       <= ST_IDLE;
         last_served_q <= REQ_IF;
         if_done_q     <= 1'b0;
         mem_done_q    <= 1'b0;
         if_data_q     <= '0;
         mem_rdata_q   <= '0;
         mem_addr_q    <= '0;
         mem_wdata_q   <= '0;
         mem_read_q    <= 1'b0;
         mem_write_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         last_served_q <= last_served_d;
         if_done_q     <= if_done_d;
         mem_done_q    <= mem_done_d;
         if_data_q     <= if_data_d;
         mem_rdata_q   <= mem_rdata_d;
         mem_addr_q    <= mem_addr_d;
         mem_wdata_q   <= mem_wdata_d;
         mem_read_q    <= mem_read_d;
         mem_write_q   <= mem_write_d;
      end
   end

   assign IFDone      = if_done_q;
   assign IFData      = if_data_q;
   assign MEMDone     = mem_done_q;
   assign MEMReadData = mem_rdata_q;
   assign MemAddr     = mem_addr_q;
   assign MemWData    = mem_wdata_q;
   assign MemRead     = mem_read_q;
   assign MemWrite    = mem_write_q;

   // Stalls follow the registered Done pulses combinationally.
   assign IFStall  = IFReq & ~if_done_q;
   assign MEMStall = mem_req & ~mem_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a timeline model of accesses checks
// every cycle, and literal checks pin the hand-computed scenarios.
module tb_mem_port_arbiter;

   localparam int L  = 2;
   localparam int AW = 32;
   localparam int DW = 32;

   logic          Clk = 1'b0;
   logic          Reset;
   logic          IFReq;
   logic [AW-1:0] IFAddress;
   logic          IFDone;
   logic [DW-1:0] IFData;
   logic          IFStall;
   logic [1:0]    MEMControl;
   logic [AW-1:0] MEMAddress;
   logic [DW-1:0] MEMWriteData;
   logic          MEMDone;
   logic [DW-1:0] MEMReadData;
   logic          MEMStall;
   logic [AW-1:0] MemAddr;
   logic [DW-1:0] MemWData;
   logic          MemRead;
   logic          MemWrite;
   logic [DW-1:0] MemRData;

   mem_port_arbiter #(
      .MEM_LATENCY (L),
      .ADDR_W      (AW),
      .DATA_W      (DW)
   ) dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .IFReq        (IFReq),
      .IFAddress    (IFAddress),
      .IFDone       (IFDone),
      .IFData       (IFData),
      .IFStall      (IFStall),
      .MEMControl   (MEMControl),
      .MEMAddress   (MEMAddress),
      .MEMWriteData (MEMWriteData),
      .MEMDone      (MEMDone),
      .MEMReadData  (MEMReadData),
      .MEMStall     (MEMStall),
      .MemAddr      (MemAddr),
      .MemWData     (MemWData),
      .MemRead      (MemRead),
      .MemWrite     (MemWrite),
      .MemRData     (MemRData)
   );

   always #5 Clk = ~Clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   always @(posedge Clk) cyc++;

   // Memory contents: each word holds four times its address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a << 2;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   // Timeline model: an access sampled in idle cycle t0 drives the port in
   // cycles t0+1..t0+L, completes in t0+L+1 and frees the port at t0+L+2.
   bit            started     = 1'b0;
   bit            m_active    = 1'b0;
   bit            m_who_mem   = 1'b0;
   bit            m_last_mem  = 1'b0;
   bit            m_rd        = 1'b0;
   bit            m_wr        = 1'b0;
   bit            rdata_valid = 1'b0;
   int            m_t0        = 0;
   logic [AW-1:0] m_addr      = '0;
   logic [DW-1:0] m_wdata     = '0;
   logic [DW-1:0] e_if_data   = '0;
   logic [DW-1:0] e_mem_data  = '0;

   assign MemRData = rdata_valid ? mem_word(m_addr) : 32'hDEAD_BEEF;

   always @(negedge Clk) begin : model
      bit was_active;
      bit in_acc;
      bit is_done;
      bit e_ifdone;
      bit e_memdone;
      was_active = m_active;
      in_acc     = m_active && (cyc >= m_t0 + 1) && (cyc <= m_t0 + L);
      is_done    = m_active && (cyc == m_t0 + L + 1);
      e_ifdone   = is_done && !m_who_mem;
      e_memdone  = is_done && m_who_mem;
      if (is_done) begin
         if (!m_who_mem)  e_if_data  = mem_word(m_addr);
         else if (m_rd)   e_mem_data = mem_word(m_addr);
         m_last_mem = m_who_mem;
         m_active   = 1'b0;
      end
      if (started) begin
         chk("MemRead", {31'd0, MemRead}, {31'd0, in_acc && m_rd});
         chk("MemWrite", {31'd0, MemWrite}, {31'd0, in_acc && m_wr});
         if (in_acc) chk("MemAddr", MemAddr, m_addr);
         if (in_acc && m_wr) chk("MemWData", MemWData, m_wdata);
         chk("IFDone", {31'd0, IFDone}, {31'd0, e_ifdone});
         chk("MEMDone", {31'd0, MEMDone}, {31'd0, e_memdone});
         chk("IFData", IFData, e_if_data);
         chk("MEMReadData", MEMReadData, e_mem_data);
         chk("IFStall", {31'd0, IFStall}, {31'd0, IFReq && !e_ifdone});
         chk("MEMStall", {31'd0, MEMStall}, {31'd0, (MEMControl != 2'b00) && !e_memdone});
      end
      if (Reset) begin
         started    = 1'b1;
         m_active   = 1'b0;
         m_last_mem = 1'b0;
         e_if_data  = '0;
         e_mem_data = '0;
      end else if (started && !was_active && (IFReq || MEMControl != 2'b00)) begin
         m_who_mem = (MEMControl != 2'b00) && (!IFReq || !m_last_mem);
         m_t0      = cyc;
         m_active  = 1'b1;
         if (m_who_mem) begin
            m_addr  = MEMAddress;
            m_wdata = MEMWriteData;
            m_rd    = MEMControl[1];
            m_wr    = (MEMControl == 2'b01);
         end else begin
            m_addr  = IFAddress;
            m_wdata = '0;
            m_rd    = 1'b1;
            m_wr    = 1'b0;
         end
      end
      rdata_valid = m_active && (cyc == m_t0 + L);
   end

   task automatic step(input int n);
      repeat (n) @(posedge Clk);
      #1;
   endtask

   initial begin
      Reset        = 1'b1;
      IFReq        = 1'b1;
      IFAddress    = 32'h40;
      MEMControl   = 2'b10;
      MEMAddress   = 32'h4;
      MEMWriteData = '0;
      step(2);
      chk("rst_MemRead", {31'd0, MemRead}, 32'd0);
      chk("rst_MemWrite", {31'd0, MemWrite}, 32'd0);
      chk("rst_MemAddr", MemAddr, 32'd0);
      chk("rst_MemWData", MemWData, 32'd0);
      chk("rst_IFDone", {31'd0, IFDone}, 32'd0);
      chk("rst_MEMDone", {31'd0, MEMDone}, 32'd0);
      chk("rst_IFData", IFData, 32'd0);
      chk("rst_MEMReadData", MEMReadData, 32'd0);
      Reset = 1'b0;

      // Both pending after reset: MEM wins, then IF.
      step(1);
      chk("first_mem_read", {31'd0, MemRead}, 32'd1);
      chk("first_mem_addr", MemAddr, 32'h4);
      step(2);
      chk("first_mem_done", {31'd0, MEMDone}, 32'd1);
      chk("first_mem_data", MEMReadData, 32'h10);
      chk("first_if_not_done", {31'd0, IFDone}, 32'd0);
      step(1);
      MEMControl = 2'b00;
      step(3);
      chk("second_if_done", {31'd0, IFDone}, 32'd1);
      chk("second_if_data", IFData, 32'h100);
      step(1);
      IFReq = 1'b0;

      // MEM read of address 2; address change mid-access is ignored.
      MEMControl = 2'b10;
      MEMAddress = 32'h2;
      step(1);
      chk("rd_strobe", {31'd0, MemRead}, 32'd1);
      chk("rd_addr", MemAddr, 32'h2);
      MEMAddress = 32'h3;
      step(1);
      chk("rd_addr_held", MemAddr, 32'h2);
      step(1);
      chk("rd_done", {31'd0, MEMDone}, 32'd1);
      chk("rd_data", MEMReadData, 32'h8);
      chk("rd_stall_low", {31'd0, MEMStall}, 32'd0);
      step(1);
      MEMControl = 2'b00;

      // MEM write leaves MEMReadData untouched.
      MEMControl   = 2'b01;
      MEMAddress   = 32'h8;
      MEMWriteData = 32'h8;
      step(1);
      chk("wr_strobe", {31'd0, MemWrite}, 32'd1);
      chk("wr_no_read", {31'd0, MemRead}, 32'd0);
      chk("wr_addr", MemAddr, 32'h8);
      chk("wr_data", MemWData, 32'h8);
      step(2);
      chk("wr_done", {31'd0, MEMDone}, 32'd1);
      chk("wr_rdata_kept", MEMReadData, 32'h8);
      step(1);
      MEMControl = 2'b00;

      // Conflict after a MEM service: IF goes first.
      IFReq      = 1'b1;
      IFAddress  = 32'h44;
      MEMControl = 2'b10;
      MEMAddress = 32'h4;
      step(1);
      chk("cf_if_first_addr", MemAddr, 32'h44);
      step(2);
      chk("cf_if_done", {31'd0, IFDone}, 32'd1);
      chk("cf_if_data", IFData, 32'h110);
      chk("cf_if_stall_low", {31'd0, IFStall}, 32'd0);
      step(1);
      IFReq = 1'b0;
      step(1);
      chk("cf_mem_addr", MemAddr, 32'h4);
      step(2);
      chk("cf_mem_done", {31'd0, MEMDone}, 32'd1);
      chk("cf_mem_data", MEMReadData, 32'h10);
      step(1);
      MEMControl = 2'b00;

      // Reset during the first access cycle aborts and the request restarts.
      MEMControl = 2'b10;
      MEMAddress = 32'h20;
      step(1);
      chk("ab_strobe", {31'd0, MemRead}, 32'd1);
      Reset = 1'b1;
      step(1);
      Reset = 1'b0;
      chk("ab_strobe_low", {31'd0, MemRead}, 32'd0);
      chk("ab_no_done", {31'd0, MEMDone}, 32'd0);
      chk("ab_data_cleared", MEMReadData, 32'd0);
      step(1);
      chk("ab_restart", {31'd0, MemRead}, 32'd1);
      chk("ab_restart_addr", MemAddr, 32'h20);
      step(2);
      chk("ab_done", {31'd0, MEMDone}, 32'd1);
      chk("ab_data", MEMReadData, 32'h80);
      step(1);
      MEMControl = 2'b00;

      // Illegal 2'b11 behaves as a read.
      MEMControl = 2'b11;
      MEMAddress = 32'h10;
      step(1);
      chk("ill_read", {31'd0, MemRead}, 32'd1);
      chk("ill_no_write", {31'd0, MemWrite}, 32'd0);
      step(1);
      chk("ill_no_write2", {31'd0, MemWrite}, 32'd0);
      step(1);
      chk("ill_done", {31'd0, MEMDone}, 32'd1);
      chk("ill_data", MEMReadData, 32'h40);
      step(1);
      MEMControl = 2'b00;

      step(4);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
